// File: rtl/pll_mode_switch.sv
// -----------------------------------------------------------------------------
// pll_mode_switch
//
// Reprograms the system PLL between NTSC and PAL timing through the PLL
// reconfig controller's Avalon-MM management port. The core is held in reset
// while the clocks are being changed and until the PLL has shown a stable lock.
//
// PLL plan: 50 MHz ref, fractional VCO, outclk0 = VCO/8, outclk1 = VCO/4.
//   NTSC: VCO 429.5454 MHz   -> 53.693175 / 107.386350 MHz
//   PAL : VCO 425.627392 MHz -> 53.203424 / 106.406848 MHz
//
// Ports
//   CLK              in   management clock (50 MHz ref domain)
//   RST_N            in   synchronous active-low reset
//   pal              in   requested standard (1 = PAL, 0 = NTSC), sync to CLK
//   locked           in   PLL lock, already synchronised to CLK
//   mgmt_address     out  reconfig register address
//   mgmt_write       out  write strobe
//   mgmt_writedata   out  write data
//   mgmt_waitrequest in   controller stall
//   busy             out  reprogramming sequence in progress
//   cur_pal          out  standard currently programmed into the PLL
//   core_rst_n       out  active-low reset to the clocked core
// -----------------------------------------------------------------------------
module pll_mode_switch #(
    parameter logic [31:0] K_NTSC      = 32'd2537930535,
    parameter logic [31:0] K_PAL       = 32'd2201376210,
    parameter logic [15:0] M_HILO      = 16'h0404,
    parameter logic [15:0] C0_HILO     = 16'h0404,
    parameter logic [15:0] C1_HILO     = 16'h0202,
    parameter int          LOCK_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        pal,
    input  logic        locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        cur_pal,
    output logic        core_rst_n
);

    localparam int              CNT_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]      LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_WAIT,
        START_WAIT,
        LOCK_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic              tgt_q, tgt_d;
    logic              busy_q, busy_d;
    logic              cur_pal_q, cur_pal_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [5:0]        addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              lock_ok;
    logic              launch;
    logic              launch_tgt;
    logic [2:0]        step_nxt;

    // Register address for each step of the reprogramming sequence.
    function automatic logic [5:0] step_addr(input logic [2:0] s);
        logic [5:0] a;
        case (s)
            3'd0:    a = 6'h00;   // mode register
            3'd1:    a = 6'h04;   // M counter
            3'd2:    a = 6'h07;   // fractional M (K)
            3'd3:    a = 6'h05;   // C counter (outclk0)
            3'd4:    a = 6'h05;   // C counter (outclk1)
            default: a = 6'h02;   // start
        endcase
        return a;
    endfunction

    // Write data for each step. C counter words are
    // {9'h0, counter select[4:0], odd, bypass, hi/lo[15:0]}.
    function automatic logic [31:0] step_data(input logic [2:0] s, input logic t);
        logic [31:0] d;
        case (s)
            3'd0:    d = 32'd0;                              // waitrequest mode
            3'd1:    d = {16'h0, M_HILO};
            3'd2:    d = t ? K_PAL : K_NTSC;
            3'd3:    d = {9'h0, 5'd0, 1'b0, 1'b0, C0_HILO};
            3'd4:    d = {9'h0, 5'd1, 1'b0, 1'b0, C1_HILO};
            default: d = 32'd1;                              // start reconfig
        endcase
        return d;
    endfunction

    // Lock is only trusted once it has been high for LOCK_CYCLES consecutive
    // cycles including the present one.
    assign lock_ok  = locked && (cnt_q == CNT_MAX);
    assign step_nxt = step_q + 3'd1;

    // Sequential state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            step_q       <= 3'd0;
            tgt_q        <= 1'b0;
            busy_q       <= 1'b0;
            cur_pal_q    <= 1'b0;     // power-on PLL config is NTSC
            core_rst_n_q <= 1'b0;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= 6'h00;
            data_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tgt_q        <= tgt_d;
            busy_q       <= busy_d;
            cur_pal_q    <= cur_pal_d;
            core_rst_n_q <= core_rst_n_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    // Lock filter: counts only while the PLL is expected to be settled (IDLE
    // or LOCK_WAIT), so each reprogram starts a fresh qualification window.
    // Saturates at CNT_MAX instead of wrapping.
    always_comb begin
        cnt_d = '0;
        if ((state_q == IDLE || state_q == LOCK_WAIT) && locked) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tgt_d        = tgt_q;
        busy_d       = busy_q;
        cur_pal_d    = cur_pal_q;
        core_rst_n_d = core_rst_n_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        data_d       = data_q;
        launch       = 1'b0;
        launch_tgt   = pal;

        case (state_q)
            IDLE: begin
                if (pal != cur_pal_q) begin
                    launch = 1'b1;
                end else begin
                    core_rst_n_d = lock_ok;
                end
            end

            // Write fields are held from entry until the controller takes them.
            WR: begin
                if (!mgmt_waitrequest) begin
                    wr_d    = 1'b0;
                    state_d = WR_WAIT;
                end
            end

            WR_WAIT: begin
                if (step_q != LAST_STEP) begin
                    step_d  = step_nxt;
                    wr_d    = 1'b1;
                    addr_d  = step_addr(step_nxt);
                    data_d  = step_data(step_nxt, tgt_q);
                    state_d = WR;
                end else begin
                    state_d = START_WAIT;
                end
            end

            // The controller keeps waitrequest high while it reconfigures.
            START_WAIT: begin
                if (!mgmt_waitrequest) begin
                    state_d = LOCK_WAIT;
                end
            end

            LOCK_WAIT: begin
                if (lock_ok) begin
                    cur_pal_d = tgt_q;
                    if (pal != tgt_q) begin
                        // Request moved while we were busy: chain straight into
                        // the next sequence so the core never sees a release.
                        launch = 1'b1;
                    end else begin
                        busy_d       = 1'b0;
                        core_rst_n_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            tgt_d        = launch_tgt;
            busy_d       = 1'b1;
            core_rst_n_d = 1'b0;
            step_d       = 3'd0;
            wr_d         = 1'b1;
            addr_d       = step_addr(3'd0);
            data_d       = step_data(3'd0, launch_tgt);
            state_d      = WR;
        end
    end

    assign mgmt_address   = addr_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = data_q;
    assign busy           = busy_q;
    assign cur_pal        = cur_pal_q;
    assign core_rst_n     = core_rst_n_q;

endmodule

// File: tb/tb_pll_mode_switch.sv
// -----------------------------------------------------------------------------
// tb_pll_mode_switch
//
// Directed scenarios with randomised stalls, start-hold lengths and lock-loss
// timing. The reference model is the register write list written out from the
// mode tables plus a run-length count of consecutive locked cycles: the core
// must leave reset exactly on the LOCK_CYCLES-th consecutive locked edge after
// reprogramming has finished.
// -----------------------------------------------------------------------------
module tb_pll_mode_switch;

    localparam int          LOCK_CYCLES = 1024;
    localparam logic [31:0] K_NTSC      = 32'd2537930535;
    localparam logic [31:0] K_PAL       = 32'd2201376210;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        pal = 1'b0;
    logic        locked = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        cur_pal;
    logic        core_rst_n;

    pll_mode_switch #(
        .K_NTSC      (K_NTSC),
        .K_PAL       (K_PAL),
        .M_HILO      (16'h0404),
        .C0_HILO     (16'h0404),
        .C1_HILO     (16'h0202),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .pal              (pal),
        .locked           (locked),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .busy             (busy),
        .cur_pal          (cur_pal),
        .core_rst_n       (core_rst_n)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int run_len = 0;
    int hit_cyc = -1;
    int rise_cyc = -1;
    int stall_pct = 0;
    int start_hold = 2;
    int hold_left = 0;
    int relock_left = 0;
    int drop_left = 0;
    int drop_after = 0;
    int force_left = 0;
    int busy_gap = 0;
    int c0 = 0;
    bit drop_armed = 0;
    bit reconf = 0;
    bit watch_busy = 0;
    bit prev_stall = 0;
    logic [5:0]  force_addr = 6'h3f;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic [37:0] acc_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {address, data} of write i when programming standard p.
    function automatic logic [37:0] exp_wr(input int i, input logic p);
        case (i)
            0:       return {6'h00, 32'd0};
            1:       return {6'h04, 32'h0000_0404};
            2:       return {6'h07, p ? K_PAL : K_NTSC};
            3:       return {6'h05, 32'h0000_0404};
            4:       return {6'h05, 32'h0004_0202};
            default: return {6'h02, 32'd1};
        endcase
    endfunction

    task automatic check_writes(input string tag, input int base, input logic p);
        logic [37:0] got;
        for (int i = 0; i < 6; i++) begin
            got = 'x;
            if (base + i < acc_q.size()) got = acc_q[base + i];
            check($sformatf("%s_w%0d", tag, i), got, exp_wr(i, p));
        end
    endtask

    // One clock: update the model from the edge just past, sample outputs,
    // then drive waitrequest/locked for the next edge like a PLL + controller.
    task tick();
        @(negedge CLK);
        cyc++;
        if (RST_N && locked) run_len++;
        else run_len = 0;
        if (run_len == LOCK_CYCLES) hit_cyc = cyc;
        if (core_rst_n && rise_cyc < 0) rise_cyc = cyc;
        if (watch_busy && !busy && !core_rst_n) busy_gap++;
        if (prev_stall) begin
            check("stall_wr", mgmt_write, 1'b1);
            check("stall_addr", mgmt_address, prev_addr);
            check("stall_data", mgmt_writedata, prev_data);
        end
        if (drop_armed && run_len == drop_after) begin
            drop_left  = 100;
            drop_armed = 0;
        end
        if (reconf && relock_left > 0) begin
            relock_left--;
            if (relock_left == 0) reconf = 0;
        end
        if (drop_left > 0) begin
            locked = 1'b0;
            drop_left--;
        end else begin
            locked = !reconf;
        end
        if (mgmt_write) begin
            if (mgmt_address == force_addr && force_left > 0) begin
                mgmt_waitrequest = 1'b1;
                force_left--;
            end else begin
                mgmt_waitrequest = ($urandom_range(0, 99) < stall_pct);
            end
        end else if (hold_left > 0) begin
            mgmt_waitrequest = 1'b1;
            hold_left--;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
        prev_stall = mgmt_write && mgmt_waitrequest;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;
        if (RST_N && mgmt_write && !mgmt_waitrequest) begin
            acc_q.push_back({mgmt_address, mgmt_writedata});
            if (mgmt_address == 6'h00) begin
                reconf      = 1;    // PLL drops lock while being reprogrammed
                relock_left = 0;
            end
            if (mgmt_address == 6'h02) begin
                hold_left   = start_hold;
                relock_left = start_hold + 3 + int'($urandom_range(0, 15));
            end
        end
    endtask

    task run_until_release(input string tag, input int budget);
        rise_cyc = -1;
        hit_cyc  = -1;
        for (int i = 0; i < budget && rise_cyc < 0; i++) tick();
        check({tag, "_rise_seen"}, rise_cyc >= 0, 1'b1);
        check({tag, "_rise_cyc"}, rise_cyc, hit_cyc);
    endtask

    task start_seq(input logic p);
        acc_q.delete();
        pal = p;
        tick();
        check("seq_busy_rise", busy, 1'b1);
        check("seq_core_low", core_rst_n, 1'b0);
        watch_busy = 1;
        busy_gap   = 0;
    endtask

    task end_seq(input string tag);
        watch_busy = 0;
        check({tag, "_busy_gap"}, busy_gap, 0);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        // Power-on reset with NTSC requested and a locked PLL
        RST_N = 1'b0;
        repeat (3) tick();
        check("rst_write", mgmt_write, 1'b0);
        check("rst_addr", mgmt_address, 6'h00);
        check("rst_data", mgmt_writedata, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_cur_pal", cur_pal, 1'b0);
        check("rst_core", core_rst_n, 1'b0);
        RST_N = 1'b1;
        c0 = cyc;
        run_until_release("por", LOCK_CYCLES + 100);
        check("por_latency", rise_cyc - c0, LOCK_CYCLES);
        check("por_no_writes", acc_q.size(), 0);
        check("por_cur_pal", cur_pal, 1'b0);

        // NTSC -> PAL, no stalls
        start_hold = 2;
        start_seq(1'b1);
        run_until_release("pal", 3000);
        end_seq("pal");
        check("pal_count", acc_q.size(), 6);
        check_writes("pal", 0, 1'b1);
        check("pal_cur_pal", cur_pal, 1'b1);

        // PAL -> NTSC with a 3-cycle stall on the K write
        force_addr = 6'h07;
        force_left = 3;
        start_seq(1'b0);
        run_until_release("stall", 3000);
        end_seq("stall");
        check("stall_used", force_left, 0);
        check("stall_count", acc_q.size(), 6);
        check_writes("stall", 0, 1'b0);
        check("stall_cur_pal", cur_pal, 1'b0);

        // Long controller hold after start, lock lost for 100 cycles mid-filter
        start_hold = 500;
        drop_after = 200 + int'($urandom_range(0, 400));
        drop_armed = 1;
        start_seq(1'b1);
        run_until_release("lockdrop", 4000);
        end_seq("lockdrop");
        check("lockdrop_done", drop_armed, 1'b0);
        check_writes("lockdrop", 0, 1'b1);
        check("lockdrop_cur_pal", cur_pal, 1'b1);

        // Lock loss while idle: reset the core, no reprogramming
        acc_q.delete();
        drop_left = 5 + int'($urandom_range(0, 20));
        tick();
        tick();
        check("idle_lockloss_core", core_rst_n, 1'b0);
        run_until_release("idle_relock", LOCK_CYCLES + 100);
        check("idle_no_writes", acc_q.size(), 0);
        check("idle_busy", busy, 1'b0);
        check("idle_cur_pal", cur_pal, 1'b1);

        // Random stalls on every write, random start hold
        stall_pct  = 40;
        start_hold = int'($urandom_range(1, 50));
        start_seq(1'b0);
        run_until_release("rand", 4000);
        end_seq("rand");
        stall_pct = 0;
        check("rand_count", acc_q.size(), 6);
        check_writes("rand", 0, 1'b0);
        check("rand_cur_pal", cur_pal, 1'b0);

        // Request flips back while an NTSC->PAL sequence is running
        start_hold = 5;
        start_seq(1'b1);
        repeat ($urandom_range(2, 12)) tick();
        pal = 1'b0;
        run_until_release("chain", 6000);
        end_seq("chain");
        check("chain_count", acc_q.size(), 12);
        check_writes("chain_a", 0, 1'b1);
        check_writes("chain_b", 6, 1'b0);
        check("chain_cur_pal", cur_pal, 1'b0);

        // Reset while the first C counter write is pending
        force_addr = 6'h05;
        force_left = 1000;
        start_seq(1'b1);
        for (int i = 0; i < 100 && !(mgmt_write && mgmt_address == 6'h05); i++) tick();
        check("abort_reached", mgmt_write && mgmt_address == 6'h05, 1'b1);
        check("abort_prior_writes", acc_q.size(), 3);
        watch_busy = 0;
        RST_N      = 1'b0;
        prev_stall = 0;
        force_left = 0;
        tick();
        check("abort_write", mgmt_write, 1'b0);
        check("abort_addr", mgmt_address, 6'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_core", core_rst_n, 1'b0);
        check("abort_cur_pal", cur_pal, 1'b0);
        RST_N       = 1'b1;
        reconf      = 0;
        relock_left = 0;
        hold_left   = 0;
        acc_q.delete();
        run_until_release("abort_redo", 3000);
        check("abort_redo_count", acc_q.size(), 6);
        check_writes("abort_redo", 0, 1'b1);
        check("abort_redo_cur_pal", cur_pal, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
